// File: rtl/fsm_vedacao_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_vedacao_multi_if
//  Purpose  : Sensor/status bundle between the filling-line stations and the
//             multi-channel seal-verification controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface fsm_vedacao_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) ();
    logic [N_CH-1:0]  PG;
    logic [N_CH-1:0]  CH;
    logic [N_CH-1:0]  RO;
    logic [N_CH-1:0]  CLR_FAULT;
    logic [N_CH-1:0]  NADA;
    logic [N_CH-1:0]  EV;
    logic [N_CH-1:0]  CHEIA;
    logic [N_CH-1:0]  VE;
    logic [N_CH-1:0]  FAULT;
    logic [CNT_W-1:0] SEAL_CNT;

    // Station / supervisor side: drives sensors and fault clears
    modport master (
        output PG, CH, RO, CLR_FAULT,
        input  NADA, EV, CHEIA, VE, FAULT, SEAL_CNT
    );

    // Controller side
    modport slave (
        input  PG, CH, RO, CLR_FAULT,
        output NADA, EV, CHEIA, VE, FAULT, SEAL_CNT
    );
endinterface
`default_nettype wire

// File: rtl/fsm_vedacao_multi.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_vedacao_multi
//  Purpose  : N independent Moore FSMs (IDLE->FILL->FULL->SEALED, plus a
//             sticky FAULT) checking fill and seal per station, with a shared
//             saturating count of completed seals.
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_vedacao_multi #(
    parameter int N_CH        = 4,
    parameter int CONFIRM_CYC = 1,
    parameter int TIMEOUT_CYC = 15,
    parameter int LEAK_FAULT  = 1,
    parameter int CNT_W       = 8
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    fsm_vedacao_multi_if.slave  bus
);

    localparam int c_TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_CNF_W = (CONFIRM_CYC > 1) ? $clog2(CONFIRM_CYC) : 1;
    localparam int c_INC_W = $clog2(N_CH + 1);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNF_W-1:0] c_CNF_LAST = c_CNF_W'(CONFIRM_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_FULL   = 3'd2,
        S_SEALED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // Leak reaction is fixed at elaboration time
    localparam state_t c_LEAK_DEST = (LEAK_FAULT != 0) ? S_FAULT : S_IDLE;

    logic [N_CH-1:0]    w_seal;
    logic [c_INC_W-1:0] w_inc;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_seal_cnt_nxt;
    logic [CNT_W-1:0]   r_seal_cnt;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t             r_state;
            state_t             w_state_nxt;
            logic [c_TMR_W-1:0] r_timer;
            logic [c_TMR_W-1:0] w_timer_nxt;
            logic [c_CNF_W-1:0] r_cnt;
            logic [c_CNF_W-1:0] w_cnt_nxt;
            logic               w_a;
            logic               w_b;
            logic               w_leak;
            logic               w_seal_ch;

            assign w_a    = bus.PG[gi] & ~bus.CH[gi] &  bus.RO[gi];
            assign w_b    = bus.PG[gi] &  bus.CH[gi] &  bus.RO[gi];
            assign w_leak = bus.PG[gi] &  bus.CH[gi] & ~bus.RO[gi];

            // Channel state, fill timer and confirmation counter registers
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_timer <= w_timer_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // Next state; timer/cnt only survive while staying in FILL/FULL
            always_comb begin
                w_state_nxt = r_state;
                w_timer_nxt = '0;
                w_cnt_nxt   = '0;
                w_seal_ch   = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_a) w_state_nxt = S_FILL;
                    end
                    S_FILL: begin
                        if (w_b) begin
                            w_state_nxt = S_FULL;
                        end else if (w_a) begin
                            if (r_timer == c_TMR_LAST) w_state_nxt = S_FAULT;
                            else                       w_timer_nxt = r_timer + c_TMR_W'(1);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_FULL: begin
                        if (w_b) begin
                            if (r_cnt == c_CNF_LAST) begin
                                w_state_nxt = S_SEALED;
                                w_seal_ch   = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + c_CNF_W'(1);
                            end
                        end else if (w_leak) begin
                            w_state_nxt = c_LEAK_DEST;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_SEALED: begin
                        if (w_b)         w_state_nxt = S_SEALED;
                        else if (w_leak) w_state_nxt = c_LEAK_DEST;
                        else             w_state_nxt = S_IDLE;
                    end
                    S_FAULT: begin
                        if (bus.CLR_FAULT[gi]) w_state_nxt = S_IDLE;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            assign w_seal[gi]    = w_seal_ch;
            assign bus.NADA[gi]  = (r_state == S_IDLE);
            assign bus.EV[gi]    = (r_state == S_FILL);
            assign bus.CHEIA[gi] = (r_state == S_FULL);
            assign bus.VE[gi]    = (r_state == S_SEALED);
            assign bus.FAULT[gi] = (r_state == S_FAULT);
        end
    endgenerate

    // Count channels sealing this edge and add with saturation
    always_comb begin
        w_inc = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_inc = w_inc + c_INC_W'(w_seal[k]);
        end
        w_sum = {1'b0, r_seal_cnt} + (CNT_W + 1)'(w_inc);
        if (w_sum[CNT_W]) w_seal_cnt_nxt = '1;
        else              w_seal_cnt_nxt = w_sum[CNT_W-1:0];
    end

    // Shared seal counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_seal_cnt <= '0;
        else      r_seal_cnt <= w_seal_cnt_nxt;
    end

    assign bus.SEAL_CNT = r_seal_cnt;

endmodule
`default_nettype wire
